// File: rtl/apb_timer_pkg.sv
// Shared definitions for the APB timer: register word indices, CTRL bit positions
// and the bus access FSM state type.
package apb_timer_pkg;

  // Register word indices, i.e. addr[4:2]
  localparam logic [2:0] RegCtrl     = 3'd0;
  localparam logic [2:0] RegPrescale = 3'd1;
  localparam logic [2:0] RegLoad     = 3'd2;
  localparam logic [2:0] RegCount    = 3'd3;
  localparam logic [2:0] RegStatus   = 3'd4;

  localparam int unsigned CtrlEnBit         = 0;
  localparam int unsigned CtrlAutoReloadBit = 1;
  localparam int unsigned CtrlIrqEnBit      = 2;
  localparam int unsigned CtrlW             = 3;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StDone
  } acc_state_e;

endpackage

// File: rtl/apb_timer_prescaler.sv
// Prescaler for the APB timer: counts 0..prescale while enabled and pulses tick on
// the cycle whose edge wraps the count back to 0.
module apb_timer_prescaler #(
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  nReset,
  input  logic                  en,
  input  logic                  clear,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  localparam logic [PRESCALE_W-1:0] One = 1;

  logic [PRESCALE_W-1:0] cnt_q, cnt_d;
  logic                  wrap;

  always_comb begin
    // >= so a prescale value lowered below the running count still wraps promptly
    wrap  = (cnt_q >= prescale);
    tick  = en && wrap;
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = wrap ? '0 : cnt_q + One;
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/apb_timer.sv
// APB down-counting timer with prescaler, auto-reload, sticky expiry flag and level irq.
// Bus accesses complete after WAIT_STATES enable cycles with ready held low.
module apb_timer
  import apb_timer_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned PRESCALE_W  = 16
) (
  input  logic        clk,
  input  logic        nReset,
  input  logic        sel,
  input  logic        enable,
  input  logic        write,
  input  logic [31:0] addr,
  input  logic [31:0] wData,
  output logic [31:0] rData,
  output logic        ready,
  output logic        slvErr,
  output logic        irq
);

  // The first enable cycle counts as a wait cycle, so WAIT spans WAIT_STATES-1 cycles.
  localparam logic [2:0] WaitLast = (WAIT_STATES > 1) ? 3'(WAIT_STATES - 1) : 3'd1;

  acc_state_e state_q, state_d;
  logic [2:0] wait_cnt_q, wait_cnt_d;

  logic [CtrlW-1:0]      ctrl_q, ctrl_d;
  logic [PRESCALE_W-1:0] presc_q, presc_d;
  logic [31:0]           load_q, load_d;
  logic [31:0]           count_q, count_d;
  logic                  expired_q, expired_d;

  logic        complete;
  logic [2:0]  reg_idx;
  logic        acc_err;
  logic        wr_ok;
  logic        wr_ctrl, wr_presc, wr_load, wr_status;
  logic        expire;
  logic        presc_clear;
  logic        tick;
  logic [31:0] rd_mux;
  logic        unused_addr;

  assign reg_idx     = addr[4:2];
  assign unused_addr = ^{addr[31:5], addr[1:0]};

  // Access FSM: state register
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q    <= StIdle;
      wait_cnt_q <= 3'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Access FSM: next state
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (sel && enable) begin
          if (WAIT_STATES <= 1) begin
            state_d = StDone;
          end else begin
            state_d    = StWait;
            wait_cnt_d = 3'd1;
          end
        end
      end
      StWait: begin
        if (!sel) begin
          state_d = StIdle;
        end else if (wait_cnt_q == WaitLast) begin
          state_d = StDone;
        end else begin
          wait_cnt_d = wait_cnt_q + 3'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Access FSM: outputs. With no wait states the first enable cycle completes and
  // DONE is only a turnaround cycle.
  always_comb begin
    if (WAIT_STATES == 0) begin
      complete = (state_q == StIdle) && sel && enable;
    end else begin
      complete = (state_q == StDone) && sel;
    end
    complete = complete && nReset;

    acc_err = (reg_idx > RegStatus) || (write && (reg_idx == RegCount));
    ready   = complete;
    slvErr  = complete && acc_err;
    rData   = (complete && !write) ? rd_mux : 32'd0;
  end

  always_comb begin
    case (reg_idx)
      RegCtrl:     rd_mux = {{(32 - CtrlW){1'b0}}, ctrl_q};
      RegPrescale: rd_mux = 32'(presc_q);
      RegLoad:     rd_mux = load_q;
      RegCount:    rd_mux = count_q;
      RegStatus:   rd_mux = {31'd0, expired_q};
      default:     rd_mux = 32'd0;
    endcase
  end

  assign wr_ok     = complete && write && !acc_err;
  assign wr_ctrl   = wr_ok && (reg_idx == RegCtrl);
  assign wr_presc  = wr_ok && (reg_idx == RegPrescale);
  assign wr_load   = wr_ok && (reg_idx == RegLoad);
  assign wr_status = wr_ok && (reg_idx == RegStatus);

  assign presc_clear = wr_load || (wr_ctrl && !ctrl_q[CtrlEnBit] && wData[CtrlEnBit]);

  apb_timer_prescaler #(
    .PRESCALE_W(PRESCALE_W)
  ) u_prescaler (
    .clk     (clk),
    .nReset  (nReset),
    .en      (ctrl_q[CtrlEnBit]),
    .clear   (presc_clear),
    .prescale(presc_q),
    .tick    (tick)
  );

  // Register next state. Bus writes are applied after timer events so they take priority.
  always_comb begin
    ctrl_d    = ctrl_q;
    presc_d   = presc_q;
    load_d    = load_q;
    count_d   = count_q;
    expired_d = expired_q;
    expire    = 1'b0;

    if (wr_load) begin
      load_d  = wData;
      count_d = wData;
    end else if (tick) begin
      if (count_q != 32'd0) begin
        count_d = count_q - 32'd1;
      end else begin
        expire = 1'b1;
        if (ctrl_q[CtrlAutoReloadBit]) begin
          count_d = load_q;
        end else begin
          ctrl_d[CtrlEnBit] = 1'b0;
        end
      end
    end

    if (wr_ctrl) begin
      ctrl_d = wData[CtrlW-1:0];
    end
    if (wr_presc) begin
      presc_d = wData[PRESCALE_W-1:0];
    end
    if (wr_status && wData[0]) begin
      expired_d = 1'b0;
    end
    // A new expiry beats a simultaneous clear
    if (expire) begin
      expired_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      ctrl_q    <= '0;
      presc_q   <= '0;
      load_q    <= '0;
      count_q   <= '0;
      expired_q <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      presc_q   <= presc_d;
      load_q    <= load_d;
      count_q   <= count_d;
      expired_q <= expired_d;
    end
  end

  assign irq = expired_q && ctrl_q[CtrlIrqEnBit];

endmodule

// File: doc/apb_timer.md
APB_TIMER -- requirements
Module: apb_timer

Interface
REQ-001 Parameter WAIT_STATES, default 1; number of cycles ready is held low after enable rises, before completion (0..7).
REQ-002 Parameter PRESCALE_W, default 16; width of the prescaler register and counter.
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 nReset  in  1  asynchronous active-low reset.
REQ-006 sel  in  1  APB select for this subordinate, driven by the upstream APB bridge.
REQ-007 enable  in  1  APB access-phase strobe.
REQ-008 write  in  1  1=write, 0=read.
REQ-009 addr  in  32  byte address; only addr[4:2] decoded, addr[1:0] ignored.
REQ-010 wData  in  32  write data.
REQ-011 rData  out  32  read data; valid only in the completion cycle.
REQ-012 ready  out  1  transfer completion.
REQ-013 slvErr  out  1  error response; valid only in the completion cycle.
REQ-014 irq  out  1  level interrupt, equal to STATUS.expired AND CTRL.irqEn.

Function
REQ-015 Register map (word offsets):
- 0x00 CTRL RW: bit0 en, bit1 autoReload, bit2 irqEn; other bits read 0.
- 0x04 PRESCALE RW: bits [PRESCALE_W-1:0].
- 0x08 LOAD RW: 32-bit.
- 0x0C COUNT RO: 32-bit.
- 0x10 STATUS: bit0 expired, write-1-to-clear.
REQ-016 Access FSM states:
- IDLE -> WAIT when sel=1 and enable=1 with WAIT_STATES>0.
- WAIT -> DONE after WAIT_STATES cycles.
- IDLE -> DONE directly when WAIT_STATES=0, so ready is combinationally high in the first enable cycle.
- DONE -> IDLE unconditionally.
REQ-017 ready is 1 only in the completion cycle; 0 in all other cycles.
REQ-018 rData is 0 outside the completion cycle.
REQ-019 If sel drops before completion, the FSM returns to IDLE and the access has no effect.
REQ-020 Register writes commit at the clock edge ending the completion cycle.
REQ-021 Reads return the register value present in the completion cycle.
REQ-022 Writes to COUNT and offsets 0x14-0x1C: slvErr=1, no state change.
REQ-023 Reads of 0x14-0x1C: slvErr=1, rData=0.
REQ-024 Prescaler counts 0..PRESCALE while CTRL.en=1; tick asserts when the prescaler wraps to 0; PRESCALE=0 gives a tick every cycle.
REQ-025 On tick:
- COUNT!=0: COUNT decrements by 1.
- COUNT==0: STATUS.expired sets; if autoReload=1, COUNT<=LOAD; else CTRL.en clears and COUNT stays 0.
REQ-026 Writing LOAD also loads COUNT with the same value and clears the prescaler.
REQ-027 Writing CTRL with en changing 0->1 clears the prescaler.
REQ-028 Simultaneous events:
- Expiry in the same cycle as a STATUS W1C: expired remains 1 (set wins).
- One-shot expiry clearing en in the same cycle as a CTRL write: the written value wins.
- Tick in the same cycle as a LOAD write: the LOAD write wins.
REQ-029 COUNT arithmetic is unsigned 32-bit; it never wraps below 0.

Reset
REQ-030 nReset low forces, immediately and regardless of any in-flight transfer:
- all registers to 0 and the prescaler to 0;
- the FSM to IDLE;
- ready=0, slvErr=0, rData=0, irq=0.

Structure
REQ-031 Package apb_timer_pkg holds the register offset constants, CTRL bit-index constants, and the access FSM state enum.
REQ-032 Prescaler and tick generation live in sub-module apb_timer_prescaler (inputs: en, clear, prescale; output: tick).

Verification
REQ-033 PRESCALE=0, LOAD=3, CTRL=0x1 -> expired sets 4 cycles after en commits; en clears; COUNT stays 0.
REQ-034 PRESCALE=2, LOAD=1, CTRL=0x7 -> irq rises after 6 cycles; COUNT reloads to 1; expiries repeat every 6 cycles.
REQ-035 WAIT_STATES=2 read of LOAD=0xA5A5A5A5 -> ready low for 2 enable cycles, then high 1 cycle with rData=0xA5A5A5A5, slvErr=0.
REQ-036 Write to 0x0C and read of 0x18 -> slvErr=1 in each completion cycle; COUNT unchanged; rData=0.
REQ-037 STATUS W1C issued in the same cycle as an expiry -> expired reads 1 afterwards.
REQ-038 nReset asserted during WAIT -> ready=0 immediately; after release, all registers read 0.
